ddr_arbiter: RTL
================

// Module: ddr_arbiter
// PURPOSE
//  Shares the single-port Ddr controller between two requesters: port 0 (VGA line fetch, high priority)
//  and port 1 (drawing engine). Also schedules periodic auto-refresh. Sits between the requesters and Ddr.
//  Keeps one transaction outstanding at a time. Each transaction is one 32-bit word (burst of 2 x 16).
// PARAMETERS
//  ADDR_W        24    word address width: {row13, bank2, col9}
//  REFRESH_CYC   1037  clk133_p cycles between refresh requests (7.8 us at 133 MHz)
//  STARVE_LIMIT  8     max consecutive port-0 grants while port 1 is pending
// PORTS
//  clk133_p      in   1       system clock, 133 MHz
//  rst           in   1       asynchronous, active-low reset
//  req0/req1     in   1       request level; held until gnt
//  wr0/wr1       in   1       1 = write, 0 = read; sampled with req
//  addr0/addr1   in   ADDR_W  word address
//  wdata0/wdata1 in   32      write data
//  gnt0/gnt1     out  1       1-cycle pulse: request accepted, inputs captured
//  done0/done1   out  1       1-cycle pulse: transaction complete; rdata valid on reads
//  rdata         out  32      read data, valid only while done0/done1 is high
//  ddrReq        out  1       1-cycle command strobe to Ddr
//  ddrWrite      out  1       write select for ddrReq
//  ddrRefresh    out  1       1-cycle auto-refresh strobe to Ddr
//  ddrAddr       out  ADDR_W  captured address
//  ddrWriteData  out  32      captured write data
//  ddrDone       in   1       Ddr completion pulse for a command or refresh
//  ddrReadData   in   32      Ddr read word, valid with ddrDone
//  refreshLate   out  1       sticky: a refresh interval expired while the previous refresh was still pending
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. Refresh counter = REFRESH_CYC-1. Starve count 0. refreshLate 0.
//  FSM states: IDLE, ISSUE, WAIT, REFRESH, RWAIT.
//  - IDLE, refPending: go to REFRESH. Refresh outranks both ports. It never aborts an in-flight transfer.
//  - IDLE, any req: pick the winner and capture addr/wr/wdata, then go to ISSUE.
//    Winner is port 0, unless req1 is high and starve count = STARVE_LIMIT.
//  - ISSUE, 1 cycle: ddrReq=1 and the winner's gnt=1. Then go to WAIT.
//  - WAIT: on ddrDone, the owner's done=1. If it was a read, rdata=ddrReadData in the same cycle.
//    Then go to IDLE. Minimum arbitration-to-strobe latency is 2 cycles.
//  - REFRESH, 1 cycle: ddrRefresh=1, clear refPending, go to RWAIT. RWAIT: on ddrDone, go to IDLE.
//  Starve count: +1 on a port-0 grant while req1=1. Cleared on a port-1 grant or when req1=0. Saturates.
//  Refresh counter: free-running down-counter. At 0 it reloads REFRESH_CYC-1 and sets refPending.
//    If refPending is already set at that point, set refreshLate (cleared only by reset).
//  Simultaneous ddrDone and counter expiry: both take effect. The next IDLE goes to REFRESH.
//  A req dropped before gnt is legal; the arbiter re-evaluates each IDLE cycle.
//  ddrDone outside WAIT/RWAIT is ignored.
//  Reset mid-transaction: the FSM returns to IDLE immediately and no done pulse is issued.
//    Ddr is reset on the same rst.
// CONFIGURATION
//  DDR_ARB_STATS_EN defined: adds outputs grantCnt0, grantCnt1 (16 bit each), saturating at 16'hFFFF.
//    Each counts its port's gnt pulses and clears on reset.
//  DDR_ARB_STATS_EN undefined: the ports and counters are absent. Other behaviour is identical.
// STRUCTURE
//  Shared package ddr_pkg: FSM state encoding, ADDR_W, and REFRESH_CYC at 7.8 us / 7.518 ns.
//  Also the field slices of the {row, bank, col} address.
//  Sub-module ddr_refresh_timer: down-counter plus refPending/refreshLate flags, with a clear input.
//  The arbitration and FSM stay in ddr_arbiter.
// TESTING
//  1 Reset low, then release: all outputs 0. No ddrRefresh before REFRESH_CYC cycles.
//  2 req1, wr1=1, addr1=24'h000123, wdata1=32'hA5A5_5A5A: gnt1 2 cycles later with ddrReq, ddrWrite=1,
//    same addr/data. ddrDone -> done1, no done0.
//  3 req0 and req1 together as reads: port 0 granted first, port 1 granted after done0.
//    Ddr returns 32'hF0F0_0F0F -> rdata on done0.
//  4 req0 held continuously, req1 held: 8 port-0 grants, then gnt1, then port 0 resumes.
//  5 Counter expiry during WAIT: ddrRefresh exactly 1 cycle after the done pulse, before next gnt.
//    Hold ddrDone low across two expiries -> refreshLate=1.
//  6 rst low in WAIT: outputs 0 asynchronously. A late ddrDone after release -> no done pulse.
// Note: the clock port is named clk133_p and the reset port rst, as elsewhere in the design.
//  rst is active-low here.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR arbiter: FSM encoding, address layout, refresh interval.
package ddr_pkg;

  localparam int unsigned ROW_W  = 13;
  localparam int unsigned BANK_W = 2;
  localparam int unsigned COL_W  = 9;
  localparam int unsigned ADDR_W = ROW_W + BANK_W + COL_W;
  localparam int unsigned DATA_W = 32;

  // 7.8 us refresh interval at a 7.518 ns clock period, truncated to 1037 cycles
  localparam int unsigned CLK_PERIOD_PS = 7518;
  localparam int unsigned REFRESH_PS    = 7_800_000;
  localparam int unsigned REFRESH_CYC   = REFRESH_PS / CLK_PERIOD_PS;

  localparam int unsigned STARVE_LIMIT = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REFRESH,
    ST_RWAIT
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [BANK_W-1:0] bank;
    logic [COL_W-1:0]  col;
  } ddr_addr_t;

  typedef struct packed {
    logic              wr;
    ddr_addr_t         addr;
    logic [DATA_W-1:0] wdata;
  } ddr_cmd_t;

endpackage

// File: rtl/ddr_arbiter_if.sv
// Requester and DDR-side signals of the arbiter; grant counters present only with DDR_ARB_STATS_EN.
interface ddr_arbiter_if;
  import ddr_pkg::*;

  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, done0, done1;
  logic [DATA_W-1:0] rdata;
  logic              ddrReq, ddrWrite, ddrRefresh;
  logic [ADDR_W-1:0] ddrAddr;
  logic [DATA_W-1:0] ddrWriteData;
  logic              ddrDone;
  logic [DATA_W-1:0] ddrReadData;
  logic              refreshLate;
`ifdef DDR_ARB_STATS_EN
  logic [15:0]       grantCnt0, grantCnt1;
`endif

  // Arbiter side
  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ddrDone, ddrReadData,
    output gnt0, gnt1, done0, done1, rdata, ddrReq, ddrWrite, ddrRefresh, ddrAddr,
           ddrWriteData, refreshLate
`ifdef DDR_ARB_STATS_EN
    , output grantCnt0, grantCnt1
`endif
  );

  // Requesters plus DDR controller side
  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ddrDone, ddrReadData,
    input  gnt0, gnt1, done0, done1, rdata, ddrReq, ddrWrite, ddrRefresh, ddrAddr,
           ddrWriteData, refreshLate
`ifdef DDR_ARB_STATS_EN
    , input grantCnt0, grantCnt1
`endif
  );

endinterface

// File: rtl/ddr_refresh_timer.sv
// Free-running refresh down-counter; raises a pending flag each interval and a sticky late flag
// when an interval expires with the previous refresh still pending.
module ddr_refresh_timer #(
  parameter int unsigned CYCLES = 1037
) (
  input  logic clk133_p,
  input  logic rst,
  input  logic i_clr,
  output logic o_pending,
  output logic o_late
);
  localparam int unsigned      CNT_W  = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_late;

  // Expiry wins over a same-cycle clear so a fresh interval is never lost
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b0;
      r_late    <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt     <= RELOAD;
      r_pending <= 1'b1;
      if (r_pending && !i_clr) r_late <= 1'b1;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (i_clr) r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_late    = r_late;

endmodule

// File: rtl/ddr_arbiter.sv
// Two-port DDR arbiter with periodic auto-refresh, one single-word transaction in flight.
// Optional per-port saturating grant counters under DDR_ARB_STATS_EN.
module ddr_arbiter
  import ddr_pkg::*;
(
  input logic          clk133_p,
  input logic          rst,
  ddr_arbiter_if.slave arb_if
);
  localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_t              r_state;
  ddr_cmd_t            r_cmd;
  logic                r_owner;
  logic [STARVE_W-1:0] r_starve;
  logic                r_gnt0, r_gnt1, r_done0, r_done1;
  logic                r_ddr_req, r_ddr_refresh;
  logic [DATA_W-1:0]   r_rdata;

  logic     w_ref_pending, w_ref_late, w_ref_clr;
  logic     w_any_req, w_pick1, w_arbitrate;
  ddr_cmd_t w_cmd;

  assign w_any_req   = arb_if.req0 | arb_if.req1;
  assign w_pick1     = arb_if.req1 & (~arb_if.req0 | (r_starve == STARVE_MAX));
  assign w_arbitrate = (r_state == ST_IDLE) & ~w_ref_pending & w_any_req;
  assign w_ref_clr   = (r_state == ST_REFRESH);
  assign w_cmd       = w_pick1 ? ddr_cmd_t'({arb_if.wr1, arb_if.addr1, arb_if.wdata1})
                               : ddr_cmd_t'({arb_if.wr0, arb_if.addr0, arb_if.wdata0});

  ddr_refresh_timer #(.CYCLES(REFRESH_CYC)) u_refresh_timer (
    .clk133_p  (clk133_p),
    .rst       (rst),
    .i_clr     (w_ref_clr),
    .o_pending (w_ref_pending),
    .o_late    (w_ref_late)
  );

  // Strobes default low each cycle; refresh strobe is raised on the IDLE decision itself
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_owner       <= 1'b0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_ddr_req     <= 1'b0;
      r_ddr_refresh <= 1'b0;
      r_rdata       <= '0;
    end else begin
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_done0       <= 1'b0;
      r_done1       <= 1'b0;
      r_ddr_req     <= 1'b0;
      r_ddr_refresh <= 1'b0;
      r_rdata       <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_ref_pending) begin
            r_state       <= ST_REFRESH;
            r_ddr_refresh <= 1'b1;
          end else if (w_any_req) begin
            r_state <= ST_ISSUE;
            r_owner <= w_pick1;
            r_cmd   <= w_cmd;
          end
        end
        ST_ISSUE: begin
          r_state   <= ST_WAIT;
          r_ddr_req <= 1'b1;
          r_gnt0    <= ~r_owner;
          r_gnt1    <= r_owner;
        end
        ST_WAIT: begin
          if (arb_if.ddrDone) begin
            r_state <= ST_IDLE;
            r_done0 <= ~r_owner;
            r_done1 <= r_owner;
            if (!r_cmd.wr) r_rdata <= arb_if.ddrReadData;
          end
        end
        ST_REFRESH: r_state <= ST_RWAIT;
        ST_RWAIT:   if (arb_if.ddrDone) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Consecutive port-0 wins while port 1 waits
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!arb_if.req1) begin
      r_starve <= '0;
    end else if (w_arbitrate) begin
      if (w_pick1)                   r_starve <= '0;
      else if (r_starve != STARVE_MAX) r_starve <= r_starve + STARVE_W'(1);
    end
  end

  assign arb_if.gnt0         = r_gnt0;
  assign arb_if.gnt1         = r_gnt1;
  assign arb_if.done0        = r_done0;
  assign arb_if.done1        = r_done1;
  assign arb_if.rdata        = r_rdata;
  assign arb_if.ddrReq       = r_ddr_req;
  assign arb_if.ddrWrite     = r_cmd.wr;
  assign arb_if.ddrAddr      = r_cmd.addr;
  assign arb_if.ddrWriteData = r_cmd.wdata;
  assign arb_if.ddrRefresh   = r_ddr_refresh;
  assign arb_if.refreshLate  = w_ref_late;

`ifdef DDR_ARB_STATS_EN
  logic [15:0] r_grant_cnt0, r_grant_cnt1;

  // Grants pulse on the ISSUE -> WAIT transition
  always_ff @(posedge clk133_p or negedge rst) begin
    if (!rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else if (r_state == ST_ISSUE) begin
      if (!r_owner && r_grant_cnt0 != 16'hFFFF) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (r_owner && r_grant_cnt1 != 16'hFFFF)  r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign arb_if.grantCnt0 = r_grant_cnt0;
  assign arb_if.grantCnt1 = r_grant_cnt1;
`endif

endmodule
